mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares the single multi-cycle 64-bit multiplier between two requesters: req 0 is the integer execute pipe, req 1 is the secondary (AMO/address-gen) pipe.
- Performs round-robin arbitration and registers the winning operands and destination tag.
- Drives the multiplier's issue and result handshakes, buffers the result, and returns it to the owning requester.
- Forwards the global flush and keeps per-requester grant counters.

Parameters:
- TAG_W, 5: width of destination tag carried with each request (rd index).
- CNT_W, 32: width of per-requester grant counters; counters wrap.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush; aborts any in-flight operation
- req_valid_i  in  2  per-requester request valid
- req_opr_a_i  in  2x64  operand A per requester
- req_opr_b_i  in  2x64  operand B per requester
- req_func_i  in  2x4  mul function (OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU from cpu_consts)
- req_word_i  in  2  word-op (MULW) flag
- req_tag_i  in  2xTAG_W  destination tag
- req_ready_o  out  2  one-hot accept; request taken when valid & ready
- res_valid_o  out  2  one-hot result valid to owning requester
- res_data_o  out  64  result data
- res_tag_o  out  TAG_W  tag of the returned result
- res_ready_i  in  2  per-requester result accept
- mul_valid_o  out  1  issue valid to multiplier
- mul_opr_a_o  out  64  operand A to multiplier
- mul_opr_b_o  out  64  operand B to multiplier
- mul_func_o  out  4  function to multiplier
- mul_word_o  out  1  word-op to multiplier
- mul_ready_i  in  1  multiplier can accept (high only while multiplier idle)
- mul_res_i  in  64  multiplier result
- mul_res_valid_i  in  1  multiplier result valid; held until accepted
- mul_res_ready_o  out  1  result accept to multiplier
- mul_flush_o  out  1  flush to multiplier
- grant_cnt_o  out  2xCNT_W  grants per requester

Behaviour:
- Reset values: all outputs 0, operand/tag/result registers 0, state S_IDLE, rr pointer 0 (req 0 has priority first), counters 0.
- mul_flush_o = flush_i (combinational, all states).
- States and transitions:
  - S_IDLE: req_ready_o is the combinational one-hot grant. Priority: rr pointer's requester first if it is valid, else the other. No grant when flush_i. On grant: latch operands, func, word, tag and owner; increment grant_cnt[owner]; go to S_ISSUE.
  - S_ISSUE: mul_valid_o=1 with the registered operands. On mul_ready_i go to S_WAIT.
  - S_WAIT: mul_res_ready_o=1. On mul_res_valid_i capture mul_res_i into the result register and go to S_RESP.
  - S_RESP: res_valid_o[owner]=1, res_data_o/res_tag_o driven from registers, and the multiplier is already free. On res_ready_i[owner] go to S_IDLE and set rr = ~owner.
- req_ready_o is 0 outside S_IDLE: one operation in flight at a time.
- flush_i in any non-IDLE state goes to S_IDLE next cycle:
  - no res_valid_o and no result handshakes that cycle;
  - rr unchanged;
  - grant counters are not decremented.
- Simultaneous flush_i and req_valid_i in S_IDLE: no grant.
- Latency with the multiplier idle (acceptance cycle 0): res_valid_o rises at cycle 4 for word ops and cycle 6 for doubleword ops. Back-pressure on res_ready_i extends S_RESP indefinitely.
- A non-owner's res_ready_i is ignored.
- Counter overflow wraps to 0.
- Result data is passed through unmodified: sign/word handling belongs to the multiplier.
- Reset mid-operation returns everything to reset values immediately.

Test Plan:
- Req0 only: MUL a=3, b=5, tag=7, res_ready held 1 -> res_valid_o=01 at cycle 6, data 15, tag 7, grant_cnt0=1.
- Req1 MULW a=0x7FFFFFFF, b=2 -> res_valid_o=10 at cycle 4, data 0xFFFFFFFFFFFFFFFE.
- Both valid every cycle: req0 MULHU a=b=0xFFFFFFFFFFFFFFFF, req1 MULH a=b=-1 -> grants alternate 0,1,0,1. Results are 0xFFFFFFFFFFFFFFFE and 0 respectively, with correct one-hot res_valid_o.
- Flush asserted in S_WAIT -> mul_flush_o=1 that cycle, no res_valid_o, S_IDLE next cycle. A new request is then accepted normally and returns correct data.
- res_ready_i held 0 for 10 cycles in S_RESP -> res_valid_o, res_data_o and res_tag_o stable throughout, req_ready_o=0, and the pending request of the other requester is not granted until acceptance.
- Async reset deasserted-then-asserted during S_ISSUE -> all outputs 0 immediately, counters 0, the first grant after reset goes to req0.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// Bundle of the request, result, multiplier and status signals of mul_arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipes and multiplier.
interface mul_arbiter_if #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
);
  logic                  flush_i;
  logic [1:0]            req_valid_i;
  logic [1:0][63:0]      req_opr_a_i;
  logic [1:0][63:0]      req_opr_b_i;
  logic [1:0][3:0]       req_func_i;
  logic [1:0]            req_word_i;
  logic [1:0][TAG_W-1:0] req_tag_i;
  logic [1:0]            req_ready_o;
  logic [1:0]            res_valid_o;
  logic [63:0]           res_data_o;
  logic [TAG_W-1:0]      res_tag_o;
  logic [1:0]            res_ready_i;
  logic                  mul_valid_o;
  logic [63:0]           mul_opr_a_o;
  logic [63:0]           mul_opr_b_o;
  logic [3:0]            mul_func_o;
  logic                  mul_word_o;
  logic                  mul_ready_i;
  logic [63:0]           mul_res_i;
  logic                  mul_res_valid_i;
  logic                  mul_res_ready_o;
  logic                  mul_flush_o;
  logic [1:0][CNT_W-1:0] grant_cnt_o;

  modport slave (
    input  flush_i, req_valid_i, req_opr_a_i, req_opr_b_i, req_func_i, req_word_i,
           req_tag_i, res_ready_i, mul_ready_i, mul_res_i, mul_res_valid_i,
    output req_ready_o, res_valid_o, res_data_o, res_tag_o, mul_valid_o, mul_opr_a_o,
           mul_opr_b_o, mul_func_o, mul_word_o, mul_res_ready_o, mul_flush_o, grant_cnt_o
  );

  modport master (
    output flush_i, req_valid_i, req_opr_a_i, req_opr_b_i, req_func_i, req_word_i,
           req_tag_i, res_ready_i, mul_ready_i, mul_res_i, mul_res_valid_i,
    input  req_ready_o, res_valid_o, res_data_o, res_tag_o, mul_valid_o, mul_opr_a_o,
           mul_opr_b_o, mul_func_o, mul_word_o, mul_res_ready_o, mul_flush_o, grant_cnt_o
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin share of one multi-cycle multiplier between the execute pipe (req 0)
// and the AMO/address-gen pipe (req 1); one operation in flight at a time.
module mul_arbiter #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          resetn,
  mul_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  owner_q, owner_d;
  logic [63:0]           opr_a_q, opr_a_d;
  logic [63:0]           opr_b_q, opr_b_d;
  logic [3:0]            func_q, func_d;
  logic                  word_q, word_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [63:0]           res_q, res_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] grant;
  logic       grant_sel;
  logic [1:0] res_valid;
  logic       mul_valid;
  logic       mul_res_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    opr_a_d       = opr_a_q;
    opr_b_d       = opr_b_q;
    func_d        = func_q;
    word_d        = word_q;
    tag_d         = tag_q;
    res_d         = res_q;
    cnt_d         = cnt_q;
    grant         = '0;
    grant_sel     = 1'b0;
    res_valid     = '0;
    mul_valid     = 1'b0;
    mul_res_ready = 1'b0;

    // A flush abandons the operation outright: no handshakes, rr and counters kept.
    if (bus.flush_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!bus.flush_i) begin
            if (bus.req_valid_i[rr_q])       grant[rr_q]  = 1'b1;
            else if (bus.req_valid_i[~rr_q]) grant[~rr_q] = 1'b1;
          end
          if (|grant) begin
            grant_sel        = grant[1];
            owner_d          = grant_sel;
            opr_a_d          = bus.req_opr_a_i[grant_sel];
            opr_b_d          = bus.req_opr_b_i[grant_sel];
            func_d           = bus.req_func_i[grant_sel];
            word_d           = bus.req_word_i[grant_sel];
            tag_d            = bus.req_tag_i[grant_sel];
            cnt_d[grant_sel] = cnt_q[grant_sel] + CNT_W'(1);
            state_d          = S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_valid = 1'b1;
          if (bus.mul_ready_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          mul_res_ready = 1'b1;
          if (bus.mul_res_valid_i) begin
            res_d   = bus.mul_res_i;
            state_d = S_RESP;
          end
        end
        S_RESP: begin
          res_valid[owner_q] = 1'b1;
          if (bus.res_ready_i[owner_q]) begin
            rr_d    = ~owner_q;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values of the previous cycle regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      opr_a_q <= '0;
      opr_b_q <= '0;
      func_q  <= '0;
      word_q  <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      opr_a_q <= opr_a_d;
      opr_b_q <= opr_b_d;
      func_q  <= func_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready_o     = grant;
  assign bus.res_valid_o     = res_valid;
  assign bus.res_data_o      = res_q;
  assign bus.res_tag_o       = tag_q;
  assign bus.mul_valid_o     = mul_valid;
  assign bus.mul_opr_a_o     = opr_a_q;
  assign bus.mul_opr_b_o     = opr_b_q;
  assign bus.mul_func_o      = func_q;
  assign bus.mul_word_o      = word_q;
  assign bus.mul_res_ready_o = mul_res_ready;
  assign bus.mul_flush_o     = bus.flush_i;
  assign bus.grant_cnt_o     = cnt_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a latency-accurate multiplier model, directed scenarios and a
// randomized phase checked every cycle against a transaction-level reference model.
module tb_mul_arbiter;
  localparam int CW = 4;
  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic resetn;
  int   n_vec = 0;
  int   n_err = 0;

  mul_arbiter_if #(.TAG_W(5), .CNT_W(CW)) bus ();
  mul_arbiter #(.TAG_W(5), .CNT_W(CW)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mul_fn(input logic [3:0] f, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [127:0] xa, xb, p;
    logic [63:0]  pw;
    if (w) begin
      pw = {32'b0, a[31:0]} * {32'b0, b[31:0]};
      return {{32{pw[31]}}, pw[31:0]};
    end
    xa = {64'b0, a};
    xb = {64'b0, b};
    if (f == OP_MULH || f == OP_MULHSU) xa = {{64{a[63]}}, a};
    if (f == OP_MULH) xb = {{64{b[63]}}, b};
    p = xa * xb;
    return (f == OP_MUL) ? p[63:0] : p[127:64];
  endfunction

  // Multiplier: accepts only when idle, result 2 (word) or 4 (doubleword) cycles after issue.
  logic        mm_busy, mm_rv;
  logic [1:0]  mm_cnt;
  logic [63:0] mm_res;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mm_busy <= 1'b0; mm_rv <= 1'b0; mm_cnt <= 2'd0; mm_res <= 64'd0;
    end else if (bus.mul_flush_o) begin
      mm_busy <= 1'b0; mm_rv <= 1'b0;
    end else begin
      if (mm_busy) begin
        if (mm_cnt == 2'd0) begin mm_busy <= 1'b0; mm_rv <= 1'b1; end
        else mm_cnt <= mm_cnt - 2'd1;
      end else if (!mm_rv && bus.mul_valid_o) begin
        mm_busy <= 1'b1;
        mm_cnt  <= bus.mul_word_o ? 2'd0 : 2'd2;
        mm_res  <= mul_fn(bus.mul_func_o, bus.mul_word_o, bus.mul_opr_a_o, bus.mul_opr_b_o);
      end
      if (mm_rv && bus.mul_res_ready_o) mm_rv <= 1'b0;
    end
  end
  assign bus.mul_ready_i     = !mm_busy && !mm_rv;
  assign bus.mul_res_valid_i = mm_rv;
  assign bus.mul_res_i       = mm_res;

  // Reference model: one transaction at a time, result visible 4/6 cycles after grant.
  bit               m_busy, m_rr, m_owner;
  int               m_age, m_lat, m_g;
  logic [63:0]      m_data;
  logic [4:0]       m_tag;
  logic [1:0][CW-1:0] m_cnt;
  logic [1:0]       e_ready, e_res;
  logic             e_mv;

  always @(negedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_rr = 0; m_owner = 0; m_age = 0; m_lat = 0;
      m_data = '0; m_tag = '0; m_cnt = '0;
    end else begin
      e_ready = '0; e_res = '0; e_mv = 1'b0; m_g = -1;
      if (!m_busy) begin
        if (!bus.flush_i) begin
          if (bus.req_valid_i[m_rr])       m_g = int'(m_rr);
          else if (bus.req_valid_i[!m_rr]) m_g = int'(!m_rr);
        end
        if (m_g >= 0) e_ready[m_g] = 1'b1;
      end else if (!bus.flush_i) begin
        if (m_age == 1) e_mv = 1'b1;
        if (m_age >= m_lat) e_res[m_owner] = 1'b1;
      end
      check("mdl_req_ready", bus.req_ready_o, e_ready);
      check("mdl_res_valid", bus.res_valid_o, e_res);
      check("mdl_mul_valid", bus.mul_valid_o, e_mv);
      check("mdl_mul_flush", bus.mul_flush_o, bus.flush_i);
      check("mdl_grant_cnt", bus.grant_cnt_o, m_cnt);
      if (e_res != 2'b00) begin
        check("mdl_res_data", bus.res_data_o, m_data);
        check("mdl_res_tag", bus.res_tag_o, m_tag);
      end
      if (m_g >= 0) begin
        m_busy  = 1;
        m_owner = m_g[0];
        m_age   = 1;
        m_lat   = bus.req_word_i[m_g] ? 4 : 6;
        m_data  = mul_fn(bus.req_func_i[m_g], bus.req_word_i[m_g],
                         bus.req_opr_a_i[m_g], bus.req_opr_b_i[m_g]);
        m_tag   = bus.req_tag_i[m_g];
        m_cnt[m_g] = m_cnt[m_g] + CW'(1);
      end else if (m_busy) begin
        if (bus.flush_i) m_busy = 0;
        else if (m_age >= m_lat && bus.res_ready_i[m_owner]) begin
          m_busy = 0;
          m_rr   = !m_owner;
        end else m_age++;
      end
    end
  end

  task automatic set_req(input int r, input logic [3:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
    bus.req_func_i[r]  = f;
    bus.req_word_i[r]  = w;
    bus.req_opr_a_i[r] = a;
    bus.req_opr_b_i[r] = b;
    bus.req_tag_i[r]   = t;
  endtask

  task automatic wait_ready(input int r, output int n);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready_o[r] && n < 50) begin @(negedge clk); n++; end
    check("accept_seen", bus.req_ready_o[r], 1'b1);
  endtask

  task automatic wait_res(input int r, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.res_valid_o[r] && lat < 60);
    check("result_seen", bus.res_valid_o[r], 1'b1);
  endtask

  // Issue one request from requester r, return accept wait, latency and result.
  task automatic send(input int r, input logic [3:0] f, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] t, output int n, output int lat,
                      output logic [63:0] d, output logic [4:0] tg);
    set_req(r, f, w, a, b, t);
    bus.req_valid_i[r] = 1'b1;
    wait_ready(r, n);
    @(posedge clk); #1;
    bus.req_valid_i[r] = 1'b0;
    wait_res(r, lat);
    d  = bus.res_data_o;
    tg = bus.res_tag_o;
    @(posedge clk); #1;
  endtask

  int          n_w, lat, ng, nr, cyc;
  int          g[4];
  logic [63:0] d;
  logic [4:0]  tg;

  initial begin
    resetn = 1'b0;
    bus.flush_i = 1'b0; bus.req_valid_i = '0; bus.res_ready_i = 2'b11;
    bus.req_opr_a_i = '0; bus.req_opr_b_i = '0; bus.req_func_i = '0;
    bus.req_word_i = '0; bus.req_tag_i = '0;
    #2;
    check("rst_req_ready", bus.req_ready_o, 2'b00);
    check("rst_res_valid", bus.res_valid_o, 2'b00);
    check("rst_mul_valid", bus.mul_valid_o, 1'b0);
    check("rst_res_data", bus.res_data_o, 64'd0);
    check("rst_grant_cnt", bus.grant_cnt_o, '0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    send(0, OP_MUL, 1'b0, 64'd3, 64'd5, 5'd7, n_w, lat, d, tg);
    check("t1_latency", lat, 6);
    check("t1_data", d, 64'd15);
    check("t1_tag", tg, 5'd7);
    check("t1_cnt0", bus.grant_cnt_o[0], CW'(1));

    send(1, OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd3, n_w, lat, d, tg);
    check("t2_latency", lat, 4);
    check("t2_data", d, 64'hFFFF_FFFF_FFFF_FFFE);

    set_req(0, OP_MULHU, 1'b0, ALL1, ALL1, 5'd1);
    set_req(1, OP_MULH, 1'b0, ALL1, ALL1, 5'd2);
    bus.req_valid_i = 2'b11;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (bus.req_ready_o != 2'b00 && ng < 4) begin g[ng] = int'(bus.req_ready_o[1]); ng++; end
      if (bus.res_valid_o[0]) begin check("both_data0", bus.res_data_o, 64'hFFFF_FFFF_FFFF_FFFE); nr++; end
      if (bus.res_valid_o[1]) begin check("both_data1", bus.res_data_o, 64'd0); nr++; end
    end
    @(posedge clk); #1 bus.req_valid_i = 2'b00;
    check("both_grants", ng, 4);
    for (int i = 0; i < ng; i++) check("both_order", g[i], i % 2);

    bus.res_ready_i = 2'b10;
    set_req(0, OP_MUL, 1'b0, 64'd9, 64'd9, 5'd3);
    bus.req_valid_i[0] = 1'b1;
    wait_ready(0, n_w);
    @(posedge clk); #1;
    bus.req_valid_i[0] = 1'b0;
    set_req(1, OP_MUL, 1'b0, 64'd2, 64'd3, 5'd4);
    bus.req_valid_i[1] = 1'b1;
    wait_res(0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid", bus.res_valid_o, 2'b01);
      check("bp_res_data", bus.res_data_o, 64'd81);
      check("bp_res_tag", bus.res_tag_o, 5'd3);
      check("bp_req_ready", bus.req_ready_o, 2'b00);
    end
    @(posedge clk); #1 bus.res_ready_i = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_other_grant", bus.req_ready_o, 2'b10);
    @(posedge clk); #1 bus.req_valid_i[1] = 1'b0;
    wait_res(1, lat);
    check("bp_other_data", bus.res_data_o, 64'd6);
    @(posedge clk); #1;

    set_req(0, OP_MUL, 1'b0, 64'd4, 64'd6, 5'd5);
    bus.req_valid_i[0] = 1'b1;
    wait_ready(0, n_w);
    @(posedge clk); #1 bus.req_valid_i[0] = 1'b0;
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("fl_mul_flush", bus.mul_flush_o, 1'b1);
    check("fl_res_valid", bus.res_valid_o, 2'b00);
    check("fl_mul_res_ready", bus.mul_res_ready_o, 1'b0);
    @(posedge clk); #1 bus.flush_i = 1'b0;
    send(0, OP_MUL, 1'b0, 64'd7, 64'd8, 5'd9, n_w, lat, d, tg);
    check("fl_next_accept", n_w, 0);
    check("fl_next_latency", lat, 6);
    check("fl_next_data", d, 64'd56);

    set_req(0, OP_MUL, 1'b0, 64'd11, 64'd12, 5'd6);
    bus.req_valid_i[0] = 1'b1;
    wait_ready(0, n_w);
    @(posedge clk); #1 bus.req_valid_i[0] = 1'b0;
    check("rs_issue_seen", bus.mul_valid_o, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("rs_mul_valid", bus.mul_valid_o, 1'b0);
    check("rs_mul_opr_a", bus.mul_opr_a_o, 64'd0);
    check("rs_grant_cnt", bus.grant_cnt_o, '0);
    check("rs_res_tag", bus.res_tag_o, 5'd0);
    @(posedge clk); #1 resetn = 1'b1;
    set_req(1, OP_MUL, 1'b0, 64'd1, 64'd1, 5'd1);
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    check("rs_first_grant", bus.req_ready_o, 2'b01);
    @(posedge clk); #1 bus.req_valid_i = 2'b00;
    wait_res(0, lat);
    check("rs_data", bus.res_data_o, 64'd132);
    @(posedge clk); #1;

    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < 2; r++)
        set_req(r, 4'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, 5'($urandom));
      bus.req_valid_i = 2'($urandom);
      bus.res_ready_i = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      bus.flush_i     = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
    end
    bus.req_valid_i = '0; bus.flush_i = 1'b0; bus.res_ready_i = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
